// File: rtl/spi_slave_pkg.sv
// Shared field widths, opcodes, chip-select levels and FSM encoding for the SPI slave.
// Imported by the top module.
package spi_slave_pkg;

    localparam int unsigned SPI_CMD_BITS       = 8;
    localparam int unsigned SPI_ADDR_BITS      = 8;
    localparam int unsigned BRIGHTNESS_WIDTH   = 8;
    localparam int unsigned SPI_PAYLOAD_BITS   = BRIGHTNESS_WIDTH;
    localparam int unsigned MASTER_FRAME_WIDTH = SPI_CMD_BITS + SPI_ADDR_BITS + SPI_PAYLOAD_BITS;

    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
    localparam logic [7:0] SPI_CMD_READ  = 8'h03;

    localparam logic CS_ASSERT   = 1'b0;
    localparam logic CS_DEASSERT = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StWdata,
        StRdata,
        StSkip,
        StDone
    } spi_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus one extra flop for edge detection.
// Edge pulses are one sysclk wide.
module spi_sync_edge (
    input  logic sysclk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q;

    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], din_i};
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~sync_q[2];
    assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave.sv
// SPI mode 0 slave clocked by sysclk: decodes command/address/payload frames into a
// single-cycle register write strobe or a read request whose data is shifted out on miso.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int unsigned         CMD_BITS     = SPI_CMD_BITS,
    parameter int unsigned         ADDR_BITS    = SPI_ADDR_BITS,
    parameter int unsigned         PAYLOAD_BITS = SPI_PAYLOAD_BITS,
    parameter logic [CMD_BITS-1:0] CMD_WRITE    = SPI_CMD_WRITE,
    parameter logic [CMD_BITS-1:0] CMD_READ     = SPI_CMD_READ
) (
    input  logic                    sysclk,
    input  logic                    rst,
    input  logic                    sclk,
    input  logic                    cs,
    input  logic                    mosi,
    output logic                    miso,
    output logic [ADDR_BITS-1:0]    o_addr,
    output logic [PAYLOAD_BITS-1:0] o_wdata,
    output logic                    o_wr_valid,
    output logic                    o_rd_req,
    input  logic [PAYLOAD_BITS-1:0] i_rd_data,
    output logic                    o_busy
);

    localparam int unsigned MAX_W = max3(CMD_BITS, ADDR_BITS, PAYLOAD_BITS);
    localparam int unsigned CNT_W = $clog2(MAX_W) + 1;

    localparam logic [CNT_W-1:0] CMD_LAST     = CNT_W'(CMD_BITS - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST    = CNT_W'(ADDR_BITS - 1);
    localparam logic [CNT_W-1:0] PAYLOAD_LAST = CNT_W'(PAYLOAD_BITS - 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_sync_edge u_sync_sclk (
        .sysclk_i (sysclk),
        .rst_i    (rst),
        .din_i    (sclk),
        .level_o  (sclk_lvl),
        .rise_o   (sclk_rise),
        .fall_o   (sclk_fall)
    );

    spi_sync_edge u_sync_cs (
        .sysclk_i (sysclk),
        .rst_i    (rst),
        .din_i    (cs),
        .level_o  (cs_lvl),
        .rise_o   (cs_rise),
        .fall_o   (cs_fall)
    );

    spi_sync_edge u_sync_mosi (
        .sysclk_i (sysclk),
        .rst_i    (rst),
        .din_i    (mosi),
        .level_o  (mosi_lvl),
        .rise_o   (mosi_rise),
        .fall_o   (mosi_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{sclk_lvl, cs_rise, mosi_rise, mosi_fall};

    spi_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [MAX_W-1:0]        rx_q, rx_d;
    logic [MAX_W-1:0]        rx_shift;
    logic [CMD_BITS-1:0]     opcode_q, opcode_d;
    logic [ADDR_BITS-1:0]    addr_q, addr_d;
    logic [PAYLOAD_BITS-1:0] wdata_q, wdata_d;
    logic [PAYLOAD_BITS-1:0] tx_q, tx_d;
    logic                    miso_q, miso_d;
    logic                    wr_valid_q, wr_valid_d;
    logic                    rd_req_q, rd_req_d;

    // mosi and sclk share the same synchronizer depth, so mosi_lvl is the bit under this rise.
    assign rx_shift = {rx_q[MAX_W-2:0], mosi_lvl};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_d       = rx_q;
        opcode_d   = opcode_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tx_d       = tx_q;
        miso_d     = miso_q;
        wr_valid_d = 1'b0;
        rd_req_d   = 1'b0;

        if (rd_req_q) begin
            tx_d = i_rd_data;
        end

        case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d = StCmd;
                    cnt_d   = '0;
                    rx_d    = '0;
                end
            end
            StCmd: begin
                if (sclk_rise) begin
                    rx_d  = rx_shift;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CMD_LAST) begin
                        opcode_d = rx_shift[CMD_BITS-1:0];
                        state_d  = StAddr;
                        cnt_d    = '0;
                        rx_d     = '0;
                    end
                end
            end
            StAddr: begin
                if (sclk_rise) begin
                    rx_d  = rx_shift;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d = '0;
                        rx_d  = '0;
                        if (opcode_q == CMD_WRITE) begin
                            addr_d  = rx_shift[ADDR_BITS-1:0];
                            state_d = StWdata;
                        end else if (opcode_q == CMD_READ) begin
                            addr_d   = rx_shift[ADDR_BITS-1:0];
                            rd_req_d = 1'b1;
                            miso_d   = 1'b0;
                            state_d  = StRdata;
                        end else begin
                            state_d = StSkip;
                        end
                    end
                end
            end
            StWdata: begin
                if (sclk_rise) begin
                    rx_d  = rx_shift;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == PAYLOAD_LAST) begin
                        wdata_d    = rx_shift[PAYLOAD_BITS-1:0];
                        wr_valid_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = StDone;
                    end
                end
            end
            StRdata: begin
                // The first fall after the address phase presents the MSB.
                if (sclk_fall) begin
                    miso_d = tx_q[PAYLOAD_BITS-1];
                    tx_d   = {tx_q[PAYLOAD_BITS-2:0], 1'b0};
                end
                if (sclk_rise) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == PAYLOAD_LAST) begin
                        cnt_d   = '0;
                        state_d = StDone;
                    end
                end
            end
            StSkip, StDone: begin
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Chip select released mid-frame: drop everything, keep the last decoded address.
        if (state_q != StIdle && cs_lvl == CS_DEASSERT) begin
            state_d    = StIdle;
            cnt_d      = '0;
            opcode_d   = opcode_q;
            addr_d     = addr_q;
            wdata_d    = wdata_q;
            miso_d     = 1'b0;
            wr_valid_d = 1'b0;
            rd_req_d   = 1'b0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rx_q       <= '0;
            opcode_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tx_q       <= '0;
            miso_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_q       <= rx_d;
            opcode_q   <= opcode_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            tx_q       <= tx_d;
            miso_q     <= miso_d;
            wr_valid_q <= wr_valid_d;
            rd_req_q   <= rd_req_d;
        end
    end

    assign miso       = miso_q & (state_q == StRdata);
    assign o_addr     = addr_q;
    assign o_wdata    = wdata_q;
    assign o_wr_valid = wr_valid_q;
    assign o_rd_req   = rd_req_q;
    assign o_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-level SPI master drives frames while a transaction-level model
// predicts strobes, read data, miso bits and busy/idle behaviour.
module tb_spi_slave;

    localparam logic [7:0] OP_WR = 8'h02;
    localparam logic [7:0] OP_RD = 8'h03;

    logic       sysclk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] o_addr, o_wdata, i_rd_data;
    logic       o_wr_valid, o_rd_req, o_busy;

    int total = 0;
    int bad = 0;

    logic [7:0]  regmem [256];
    logic [15:0] wr_q [$];
    logic [7:0]  rd_q [$];
    logic [7:0]  exp_addr = 8'h00;
    logic [7:0]  exp_wdata = 8'h00;
    bit          frame_live = 1'b0;
    bit          rd_window = 1'b0;
    int          cs_hi_cnt = 0;
    int          cs_lo_cnt = 0;
    int          n_wr = 0;
    int          n_rd = 0;
    logic [7:0]  last_wr_addr = 8'h00;
    logic [7:0]  last_wr_data = 8'h00;
    logic [7:0]  last_rd_addr = 8'h00;

    always #4 sysclk = ~sysclk;

    always_comb i_rd_data = regmem[o_addr];

    spi_slave dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .sclk       (sclk),
        .cs         (cs),
        .mosi       (mosi),
        .miso       (miso),
        .o_addr     (o_addr),
        .o_wdata    (o_wdata),
        .o_wr_valid (o_wr_valid),
        .o_rd_req   (o_rd_req),
        .i_rd_data  (i_rd_data),
        .o_busy     (o_busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Per-cycle compare process, sampled mid-cycle away from the active edge.
    initial begin
        logic [15:0] e;
        logic [7:0]  ra;
        forever begin
            @(posedge sysclk);
            if (cs) begin
                cs_hi_cnt++;
                cs_lo_cnt = 0;
            end else begin
                cs_lo_cnt++;
                cs_hi_cnt = 0;
            end
            #2;
            if (o_wr_valid) begin
                total++;
                if (wr_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected o_wr_valid: addr 0x%0h data 0x%0h, expected none",
                             o_addr, o_wdata);
                end else begin
                    e = wr_q.pop_front();
                    check("wr strobe addr", o_addr, e[15:8]);
                    check("wr strobe data", o_wdata, e[7:0]);
                    n_wr++;
                    last_wr_addr = o_addr;
                    last_wr_data = o_wdata;
                end
            end
            if (o_rd_req) begin
                total++;
                if (rd_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected o_rd_req: addr 0x%0h, expected none", o_addr);
                end else begin
                    ra = rd_q.pop_front();
                    check("rd req addr", o_addr, ra);
                    n_rd++;
                    last_rd_addr = o_addr;
                end
            end
            if (cs_hi_cnt >= 4) check("busy while cs high", o_busy, 0);
            if (frame_live && cs_lo_cnt >= 4) check("busy during frame", o_busy, 1);
            if (cs_hi_cnt >= 4 || (cs_lo_cnt >= 1 && !rd_window)) check("miso quiet", miso, 0);
        end
    end

    task automatic pulse_reset();
        rst = 1'b1;
        frame_live = 1'b0;
        rd_window = 1'b0;
        exp_addr = 8'h00;
        exp_wdata = 8'h00;
        @(negedge sysclk);
        check("rst miso", miso, 0);
        check("rst wr_valid", o_wr_valid, 0);
        check("rst rd_req", o_rd_req, 0);
        check("rst busy", o_busy, 0);
        check("rst addr", o_addr, 0);
        check("rst wdata", o_wdata, 0);
        rst = 1'b0;
    endtask

    // Master drives nbits of {op, addr, data}; rst_at>0 pulses reset after that many rises.
    task automatic run_frame(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] data,
                             input int nbits, input int rst_at, input int h, input int gap,
                             output logic [7:0] rd_got);
        logic [23:0] word;
        logic [7:0]  rd_byte;
        logic        exp_bit;
        bit          is_rd, is_wr;
        word = {op, addr, data};
        is_rd = (op == OP_RD);
        is_wr = (op == OP_WR);
        rd_byte = regmem[addr];
        rd_got = 8'h00;
        @(negedge sysclk);
        cs = 1'b0;
        frame_live = 1'b1;
        rd_window = is_rd;
        repeat (h) @(negedge sysclk);
        for (int i = 0; i < nbits; i++) begin
            mosi = word[23-i];
            repeat (h) @(negedge sysclk);
            exp_bit = 1'b0;
            if (frame_live && is_rd && i >= 16) exp_bit = rd_byte[23-i];
            check($sformatf("miso bit %0d op 0x%0h", i, op), miso, exp_bit);
            if (is_rd && i >= 16) rd_got[23-i] = miso;
            sclk = 1'b1;
            if (frame_live) begin
                if (i == 15 && (is_rd || is_wr)) exp_addr = addr;
                if (i == 15 && is_rd) rd_q.push_back(addr);
                if (i == 23 && is_wr) begin
                    wr_q.push_back({addr, data});
                    regmem[addr] = data;
                    exp_wdata = data;
                end
            end
            repeat (h) @(negedge sysclk);
            if (i + 1 == rst_at) pulse_reset();
            sclk = 1'b0;
        end
        repeat (h) @(negedge sysclk);
        cs = 1'b1;
        mosi = 1'b0;
        frame_live = 1'b0;
        rd_window = 1'b0;
        repeat (gap) @(negedge sysclk);
        check("frame end busy", o_busy, 0);
        check("frame end addr", o_addr, exp_addr);
        check("frame end wdata", o_wdata, exp_wdata);
        check("missing wr strobes", wr_q.size(), 0);
        check("missing rd requests", rd_q.size(), 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] got, op;
        int w0, r0, nbits, rst_at, sel;
        for (int a = 0; a < 256; a++) regmem[a] = 8'($urandom);
        repeat (2) @(negedge sysclk);
        pulse_reset();
        repeat (6) @(negedge sysclk);

        // Write 02/05/A7.
        w0 = n_wr; r0 = n_rd;
        run_frame(OP_WR, 8'h05, 8'hA7, 24, 0, 4, 8, got);
        check("dir write count", n_wr - w0, 1);
        check("dir write addr", last_wr_addr, 8'h05);
        check("dir write data", last_wr_data, 8'hA7);
        check("dir write no rd", n_rd - r0, 0);

        // Read 03/05 returns the A7 just written, MSB first.
        w0 = n_wr; r0 = n_rd;
        run_frame(OP_RD, 8'h05, 8'h00, 24, 0, 5, 8, got);
        check("dir read byte", got, 8'hA7);
        check("dir read count", n_rd - r0, 1);
        check("dir read addr", last_rd_addr, 8'h05);
        check("dir read no wr", n_wr - w0, 0);

        // Abort after 12 bits, then a full write.
        w0 = n_wr;
        run_frame(OP_WR, 8'h07, 8'h99, 12, 0, 4, 8, got);
        check("abort no strobe", n_wr - w0, 0);
        run_frame(OP_WR, 8'h10, 8'h3C, 24, 0, 4, 8, got);
        check("post-abort count", n_wr - w0, 1);
        check("post-abort addr", last_wr_addr, 8'h10);
        check("post-abort data", last_wr_data, 8'h3C);

        // Unknown opcode.
        w0 = n_wr; r0 = n_rd;
        run_frame(8'hFF, 8'h05, 8'h55, 24, 0, 4, 8, got);
        check("unknown op no wr", n_wr - w0, 0);
        check("unknown op no rd", n_rd - r0, 0);

        // Reset during the address phase, then a clean frame.
        w0 = n_wr;
        run_frame(OP_WR, 8'h33, 8'h77, 24, 11, 4, 8, got);
        check("rst frame no strobe", n_wr - w0, 0);
        run_frame(OP_WR, 8'h20, 8'h5A, 24, 0, 4, 8, got);
        check("post-rst addr", last_wr_addr, 8'h20);
        check("post-rst data", last_wr_data, 8'h5A);

        // Back-to-back writes with cs high for 8 sysclk.
        w0 = n_wr;
        run_frame(OP_WR, 8'h41, 8'h11, 24, 0, 4, 8, got);
        run_frame(OP_WR, 8'h42, 8'h22, 24, 0, 4, 8, got);
        check("b2b count", n_wr - w0, 2);
        check("b2b last addr", last_wr_addr, 8'h42);
        check("b2b last data", last_wr_data, 8'h22);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) op = OP_WR;
            else if (sel < 8) op = OP_RD;
            else op = 8'($urandom);
            nbits = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 23) : 24;
            rst_at = ($urandom_range(0, 14) == 0) ? $urandom_range(1, 23) : 0;
            run_frame(op, 8'($urandom), 8'($urandom), nbits, rst_at, $urandom_range(4, 6),
                      $urandom_range(4, 10), got);
        end

        repeat (10) @(negedge sysclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
